// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the FSM state enum, funct3 size codes and wait-state limit.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int WAIT_MAX = 7;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane enables, store replication and load align/extend.
// In: size, lane, wdata, rword  Out: be, wrep, rext (all combinational).
module mem_lane_unit
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rword[{lane, 3'b000} +: 8];
  assign h = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be   = 4'b0000;
    wrep = wdata;
    rext = 32'h0;
    unique case (size)
      SZ_B, SZ_BU: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata[7:0]}};
        rext = size[2] ? {24'h0, b}
                       : {{24{b[7]}}, b};
      end
      SZ_H, SZ_HU: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
        rext = size[2] ? {16'h0, h}
                       : {{16{h[15]}}, h};
      end
      SZ_W: begin
        be   = 4'b1111;
        rext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with valid/ready request/response.
// Ports: clk, reset (async low), req_* in, req_ready out, rsp_* out, rsp_ready in.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      wrep;
  logic [31:0]      rext;
  logic             mis, oor, ill, bad;

  assign idx   = addr_q[IDX_W+1:2];
  assign rword = mem[idx];

  assign mis = ((size_q == SZ_H || size_q == SZ_HU)
                && addr_q[0])
             || (size_q == SZ_W && addr_q[1:0] != 2'b00);
  assign oor = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
  assign ill = (size_q == 3'b011) || (size_q == 3'b110)
             || (size_q == 3'b111)
             || (wr_q && (size_q == SZ_BU || size_q == SZ_HU));
  assign bad = mis | oor | ill;

  mem_lane_unit u_lane (
    .size  (size_q),
    .lane  (addr_q[1:0]),
    .wdata (wdata_q),
    .rword (rword),
    .be    (be),
    .wrep  (wrep),
    .rext  (rext)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ACCESS;
      end
      ACCESS: begin
        err_d   = bad;
        rdata_d = (bad || wr_q) ? 32'h0 : rext;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 3'b000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // No reset: contents survive reset; an aborted request
  // never reaches ACCESS so it cannot write.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && wr_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed and random traffic
// checked against a byte-addressed behavioural memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          e;
  } op_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_size = 3'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mb [4*DEPTH];

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory; loads/stores touch n bytes at a.
  function automatic void model(input bit w, input logic [31:0] a,
                                input logic [2:0] sz,
                                input logic [31:0] wd,
                                output logic [31:0] rd,
                                output bit e);
    int n;
    logic [31:0] v;
    rd = 32'h0;
    e = 1'b0;
    n = 0;
    case (sz)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    e = 1'b1;
    endcase
    if (w && sz >= 3'd4) e = 1'b1;
    if (n != 0 && (a % n) != 0) e = 1'b1;
    if ((a / 4) >= DEPTH) e = 1'b1;
    if (e) return;
    if (w) begin
      for (int i = 0; i < n; i++) mb[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8*i));
      if (sz < 3'd4 && n < 4 && v[8*n-1])
        v = v | ~((32'd1 << (8*n)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic xact(input bit w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output bit e,
                      output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_size  = 3'($urandom);
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rsp_rdata;
    e  = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_release: ready=%b valid=%b want 1 0",
               req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_word();
    op_t ops[2] = '{
      '{1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0},
      '{1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0}
    };
    logic [31:0] rd, mrd;
    bit e, me;
    int lat;
    foreach (ops[i]) begin
      model(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, mrd, me);
      xact(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, rd, e, lat);
      total_cnt++;
      if (rd !== ops[i].rd || e !== ops[i].e)
        $display("FAIL word[%0d]: rdata=%h err=%b want %h %b",
                 i, rd, e, ops[i].rd, ops[i].e);
      else pass_cnt++;
      total_cnt++;
      if (lat !== WS + 1)
        $display("FAIL word_latency[%0d]: %0d want %0d", i, lat, WS + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_extend();
    op_t ops[5] = '{
      '{1'b1, 32'h20, 3'd2, 32'h80FF7F01, 32'h0, 1'b0},
      '{1'b0, 32'h23, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0},
      '{1'b0, 32'h23, 3'd4, 32'h0, 32'h00000080, 1'b0},
      '{1'b0, 32'h22, 3'd1, 32'h0, 32'hFFFF80FF, 1'b0},
      '{1'b0, 32'h20, 3'd5, 32'h0, 32'h00007F01, 1'b0}
    };
    logic [31:0] rd, mrd;
    bit e, me;
    int lat;
    foreach (ops[i]) begin
      model(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, mrd, me);
      xact(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, rd, e, lat);
      total_cnt++;
      if (rd !== ops[i].rd || e !== ops[i].e)
        $display("FAIL extend[%0d]: rdata=%h err=%b want %h %b",
                 i, rd, e, ops[i].rd, ops[i].e);
      else pass_cnt++;
    end
  endtask

  task automatic test_partial();
    op_t ops[5] = '{
      '{1'b1, 32'h30, 3'd2, 32'h11223344, 32'h0, 1'b0},
      '{1'b1, 32'h31, 3'd0, 32'h000000AA, 32'h0, 1'b0},
      '{1'b0, 32'h30, 3'd2, 32'h0, 32'h1122AA44, 1'b0},
      '{1'b1, 32'h32, 3'd1, 32'h7777BEEF, 32'h0, 1'b0},
      '{1'b0, 32'h30, 3'd2, 32'h0, 32'hBEEFAA44, 1'b0}
    };
    logic [31:0] rd, mrd;
    bit e, me;
    int lat;
    foreach (ops[i]) begin
      model(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, mrd, me);
      xact(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, rd, e, lat);
      total_cnt++;
      if (rd !== ops[i].rd || e !== ops[i].e)
        $display("FAIL partial[%0d]: rdata=%h err=%b want %h %b",
                 i, rd, e, ops[i].rd, ops[i].e);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    op_t ops[15] = '{
      '{1'b1, 32'h00, 3'd2, 32'h01020304, 32'h0, 1'b0},
      '{1'b1, 32'h04, 3'd2, 32'hA5A5A5A5, 32'h0, 1'b0},
      '{1'b1, 32'h08, 3'd2, 32'h0BADCAFE, 32'h0, 1'b0},
      '{1'b1, 32'h0C, 3'd2, 32'h600DF00D, 32'h0, 1'b0},
      '{1'b0, 32'h02, 3'd2, 32'h0, 32'h0, 1'b1},
      '{1'b1, 32'h05, 3'd1, 32'hFFFFFFFF, 32'h0, 1'b1},
      '{1'b0, 32'h04, 3'd2, 32'h0, 32'hA5A5A5A5, 1'b0},
      '{1'b1, 32'(4*DEPTH), 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1},
      '{1'b0, 32'h00, 3'd2, 32'h0, 32'h01020304, 1'b0},
      '{1'b0, 32'(4*DEPTH), 3'd2, 32'h0, 32'h0, 1'b1},
      '{1'b1, 32'h08, 3'd3, 32'hFFFFFFFF, 32'h0, 1'b1},
      '{1'b0, 32'h08, 3'd2, 32'h0, 32'h0BADCAFE, 1'b0},
      '{1'b1, 32'h0C, 3'd5, 32'hFFFFFFFF, 32'h0, 1'b1},
      '{1'b0, 32'h0C, 3'd2, 32'h0, 32'h600DF00D, 1'b0},
      '{1'b0, 32'h0C, 3'd7, 32'h0, 32'h0, 1'b1}
    };
    logic [31:0] rd, mrd;
    bit e, me;
    int lat;
    foreach (ops[i]) begin
      model(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, mrd, me);
      xact(ops[i].w, ops[i].a, ops[i].sz, ops[i].wd, rd, e, lat);
      total_cnt++;
      if (rd !== ops[i].rd || e !== ops[i].e)
        $display("FAIL error[%0d]: rdata=%h err=%b want %h %b",
                 i, rd, e, ops[i].rd, ops[i].e);
      else pass_cnt++;
      total_cnt++;
      if (lat !== WS + 1)
        $display("FAIL error_latency[%0d]: %0d want %0d", i, lat, WS + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] wd, rd, mrd;
    bit e, me;
    int lat;
    wd = $urandom;
    model(1'b1, 32'h44, 3'd2, wd, mrd, me);
    xact(1'b1, 32'h44, 3'd2, wd, rd, e, lat);
    model(1'b0, 32'h44, 3'd2, 32'h0, mrd, me);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h44;
    req_size  = 3'd2;
    @(posedge clk);
    #1;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      req_write = 1'b1;
      req_addr  = $urandom_range(0, 255);
      req_wdata = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    total_cnt++;
    if (lat !== WS + 1)
      $display("FAIL bp_latency: %0d want %0d", lat, WS + 1);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== mrd || req_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b want 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, mrd);
      else pass_cnt++;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    total_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_release: ready=%b valid=%b want 1 0",
               req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, mrd;
    bit e, me;
    int lat;
    model(1'b1, 32'h40, 3'd2, 32'h0, mrd, me);
    xact(1'b1, 32'h40, 3'd2, 32'h0, rd, e, lat);
    xact(1'b0, 32'h10, 3'd2, 32'h0, rd, e, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_size  = 3'd2;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL abort_outputs: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model(1'b0, 32'h40, 3'd2, 32'h0, mrd, me);
    xact(1'b0, 32'h40, 3'd2, 32'h0, rd, e, lat);
    total_cnt++;
    if (rd !== 32'h0 || rd !== mrd || e !== 1'b0)
      $display("FAIL abort_readback: rdata=%h err=%b want 00000000 0", rd, e);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, mrd;
    logic [2:0] sz;
    bit w, e, me;
    int lat;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      model(1'b1, 32'(4*i), 3'd2, wd, mrd, me);
      xact(1'b1, 32'(4*i), 3'd2, wd, rd, e, lat);
      total_cnt++;
      if (e !== 1'b0 || rd !== 32'h0)
        $display("FAIL seed[%0d]: rdata=%h err=%b want 0 0", i, rd, e);
      else pass_cnt++;
    end
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      sz = 3'($urandom);
      wd = $urandom;
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) a = a + 32'(4*DEPTH);
      model(w, a, sz, wd, mrd, me);
      xact(w, a, sz, wd, rd, e, lat);
      total_cnt++;
      if (rd !== mrd || e !== me)
        $display("FAIL random[%0d] w=%b a=%h sz=%0d: rdata=%h err=%b want %h %b",
                 i, w, a, sz, rd, e, mrd, me);
      else pass_cnt++;
      total_cnt++;
      if (lat !== WS + 1)
        $display("FAIL random_latency[%0d]: %0d want %0d", i, lat, WS + 1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
